mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum ACCESS cycles to wait for mem_ready before abort; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 if_req  input  1  instruction-fetch read request; held high until if_done.
REQ-005 if_addr  input  16  fetch word address (the CPU pc).
REQ-006 if_done  output  1  one-cycle pulse: fetch transaction finished.
REQ-007 if_rdata  output  16  fetched instruction word; registered.
REQ-008 ls_req  input  1  load/store request; held high until ls_done.
REQ-009 ls_we  input  1  1 = store, 0 = load.
REQ-010 ls_addr  input  16  load/store word address (ALU result).
REQ-011 ls_wdata  input  16  store data (register read data 2).
REQ-012 ls_done  output  1  one-cycle pulse: load/store finished.
REQ-013 ls_rdata  output  16  loaded word; registered.
REQ-014 err  output  1  pulses with if_done/ls_done when the transaction timed out.
REQ-015 mem_req  output  1  memory access request, held through ACCESS.
REQ-016 mem_we  output  1  memory write enable; always 0 for fetch grants.
REQ-017 mem_addr  output  16  latched address of the granted port.
REQ-018 mem_wdata  output  16  latched store data; 16'h0000 for fetch grants and loads.
REQ-019 mem_rdata  input  16  memory read data, valid when mem_ready=1.
REQ-020 mem_ready  input  1  memory completion strobe; variable latency of 1 cycle or more.

Function
REQ-021 Three-state FSM: IDLE, ACCESS, DONE. All outputs are registered.
REQ-022 IDLE with any request: pick a winner, latch its addr/we/wdata, record the winner, and enter ACCESS on the next edge. With no request: remain in IDLE.
REQ-023 Tie (if_req and ls_req both high in IDLE): grant the port not granted last (round-robin). A single requester is always granted. Every grant updates last_gnt.
REQ-024 ACCESS: mem_req=1 with stable latched values. mem_ready=1 captures mem_rdata into the winner's rdata on a load or fetch, then enters DONE.
REQ-025 ACCESS timeout: a cycle counter clears on entry to ACCESS. When TIMEOUT cycles elapse without mem_ready, drop mem_req, write 16'h0000 to the winner's rdata (for reads), set err for the DONE cycle, and enter DONE.
REQ-026 DONE: the winner's done pulses for exactly one cycle; mem_req=0; the FSM unconditionally returns to IDLE.
REQ-027 Latency: request sampled at edge N gives mem_req high after N+1. With mem_ready in the first ACCESS cycle, done is high after N+2. Minimum period between grants is 3 cycles.
REQ-028 Stores (ls_we=1) leave ls_rdata unchanged. Each rdata holds its value until the next completed read on that port.
REQ-029 Changes on req, addr, we or wdata after the grant are ignored; the transaction completes and done still pulses.
REQ-030 mem_ready is ignored in IDLE and DONE. The losing requester waits in IDLE arbitration and is never dropped.

Reset
REQ-031 reset=0 immediately forces IDLE, including mid-ACCESS. Then: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_done=0, ls_done=0, err=0, if_rdata=0, ls_rdata=0, counter=0, last_gnt=LS (so the first tie grants IF).
REQ-032 A transaction in flight at reset is discarded and produces no done pulse. On the first edge after reset deasserts, the FSM arbitrates normally.

Structure
REQ-033 State encodings (IDLE/ACCESS/DONE), port IDs (PORT_IF=0, PORT_LS=1), and the 16-bit word-width constant live in the shared CPU package.
REQ-034 The block is a single module with no sub-modules. The round-robin chooser is inline logic.

Verification
REQ-035 if_req=1, if_addr=16'h0004, memory ready after 1 cycle with 16'hA5A5 -> mem_addr=0004 and mem_we=0; if_done pulses at N+2; if_rdata=A5A5.
REQ-036 if_req and ls_req rise together, twice in a row -> order of grants is IF, LS, IF, LS; each done pulses once.
REQ-037 ls_req=1, ls_we=1, ls_addr=16'h0010, ls_wdata=16'h1234 -> mem_we=1, mem_addr=0010, mem_wdata=1234; ls_done pulses; ls_rdata unchanged.
REQ-038 Load with mem_ready never asserted, TIMEOUT=15 -> mem_req high for exactly 15 cycles; then ls_done=1 and err=1 together; ls_rdata=0000.
REQ-039 reset=0 in the 2nd ACCESS cycle of a fetch -> mem_req=0 without a clock edge; no if_done pulse; a new request after release is granted normally.
REQ-040 Memory latency 4 cycles while ls_addr toggles during ACCESS -> mem_addr stays at the latched value throughout; ls_done pulses once.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the memory arbiter: the data word width, the
// arbiter FSM state encoding, the requester port IDs and a round-robin
// helper that names the port not granted last.
package mem_arbiter_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_t;

    function automatic port_t other_port(input port_t p);
        return (p == PORT_IF) ? PORT_LS : PORT_IF;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Memory-side bus between the arbiter and a single-ported memory.
//   req   : access request, held for the whole access
//   we    : write enable (0 for fetches and loads)
//   addr  : word address of the granted transaction
//   wdata : store data (zero for fetches and loads)
//   rdata : read data, valid while ready is high
//   ready : completion strobe from the memory
// master modport = arbiter side, slave modport = memory side.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic  req;
    logic  we;
    word_t addr;
    word_t wdata;
    word_t rdata;
    logic  ready;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ready
    );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between the instruction-fetch (IF) and the
// load/store (LS) requesters. A three-state FSM (IDLE -> ACCESS -> DONE)
// grants one transaction at a time, breaking ties round-robin, and aborts
// an access with err if the memory does not answer within TIMEOUT cycles.
// Ports:
//   clk, reset (async, active-low)
//   if_req, if_addr -> if_done, if_rdata   : fetch requester
//   ls_req, ls_we, ls_addr, ls_wdata
//                   -> ls_done, ls_rdata   : load/store requester
//   err                                    : abort flag, pulses with done
//   mem (mem_arbiter_if.master)            : memory bus
// All outputs are registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  word_t               if_addr,
    output logic                if_done,
    output word_t               if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  word_t               ls_addr,
    input  word_t               ls_wdata,
    output logic                ls_done,
    output word_t               ls_rdata,
    output logic                err,
    mem_arbiter_if.master       mem
);

    // Abort fires on the edge that closes the TIMEOUT-th ACCESS cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    port_t      winner;
    port_t      last_gnt;
    port_t      pick;
    logic [7:0] count;

    // Round-robin chooser: on a tie the port not granted last wins,
    // otherwise the only active requester wins.
    always_comb begin
        pick = PORT_IF;
        if (if_req && ls_req) begin
            pick = other_port(last_gnt);
        end else if (ls_req) begin
            pick = PORT_LS;
        end
    end

    // Arbiter FSM with registered outputs. Done and err are single-cycle
    // pulses, so they default low every cycle and are set only on the
    // ACCESS -> DONE edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            winner    <= PORT_IF;
            last_gnt  <= PORT_LS;
            count     <= '0;
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
            if_done   <= 1'b0;
            ls_done   <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (if_req || ls_req) begin
                        winner   <= pick;
                        last_gnt <= pick;
                        count    <= '0;
                        mem.req  <= 1'b1;
                        if (pick == PORT_IF) begin
                            mem.we    <= 1'b0;
                            mem.addr  <= if_addr;
                            mem.wdata <= '0;
                        end else begin
                            mem.we    <= ls_we;
                            mem.addr  <= ls_addr;
                            mem.wdata <= ls_we ? ls_wdata : '0;
                        end
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem.ready) begin
                        mem.req <= 1'b0;
                        if (!mem.we) begin
                            if (winner == PORT_IF) begin
                                if_rdata <= mem.rdata;
                            end else begin
                                ls_rdata <= mem.rdata;
                            end
                        end
                        if_done <= (winner == PORT_IF);
                        ls_done <= (winner == PORT_LS);
                        state   <= ST_DONE;
                    end else if (count == TIMEOUT_LAST) begin
                        // Timed-out reads return zero; stores keep old data.
                        mem.req <= 1'b0;
                        if (!mem.we) begin
                            if (winner == PORT_IF) begin
                                if_rdata <= '0;
                            end else begin
                                ls_rdata <= '0;
                            end
                        end
                        if_done <= (winner == PORT_IF);
                        ls_done <= (winner == PORT_LS);
                        err     <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                ST_DONE: begin
                    mem.req <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    mem.req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. The bench plays both the CPU
// (requesters drop their request when their done pulse is seen) and the
// memory (answers after a chosen latency, or never). Expected grants,
// bus values and read data come from a round-robin model kept here.
module tb_mem_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [15:0] ls_addr;
    logic [15:0] ls_wdata;
    logic        ls_done;
    logic [15:0] ls_rdata;
    logic        err;

    mem_arbiter_if mem_bus();

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_done  (ls_done),
        .ls_rdata (ls_rdata),
        .err      (err),
        .mem      (mem_bus)
    );

    always #5 clk = ~clk;

    // One observed transaction: bus values latched at the first mem req
    // cycle, how long req stayed high, and which done/err ended it.
    typedef struct {
        int          port;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        int          req_cycles;
        int          lat;
        bit          stable;
        bit          err;
    } txn_t;

    txn_t        log_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_if_rdata;
    logic [15:0] exp_ls_rdata;
    int          exp_last;

    // Round-robin reference: a tie goes to the port not served last.
    function int grant_rr(input bit a_if, input bit a_ls);
        int g;
        if (a_if && a_ls) g = 1 - exp_last;
        else              g = a_ls ? 1 : 0;
        exp_last = g;
        return g;
    endfunction

    // Plays CPU and memory for 'budget' cycles, logging every transaction.
    // latency 0 means the memory never answers.
    task automatic serve(input int latency, input logic [15:0] rd,
                         input int budget, input bit toggle);
        txn_t cur;
        bit   in_txn = 1'b0;
        int   start = 0;
        cur.port = 0; cur.addr = '0; cur.we = 1'b0; cur.wdata = '0;
        cur.req_cycles = 0; cur.lat = 0; cur.stable = 1'b1; cur.err = 1'b0;
        log_q.delete();
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mem_bus.req && !in_txn) begin
                in_txn = 1'b1;
                start = i;
                cur.addr = mem_bus.addr;
                cur.we = mem_bus.we;
                cur.wdata = mem_bus.wdata;
                cur.req_cycles = 0;
                cur.stable = 1'b1;
            end
            if (mem_bus.req) begin
                cur.req_cycles++;
                if (mem_bus.addr !== cur.addr || mem_bus.we !== cur.we ||
                    mem_bus.wdata !== cur.wdata) cur.stable = 1'b0;
            end
            if (if_done || ls_done) begin
                cur.port = (if_done && ls_done) ? 2 : (if_done ? 0 : 1);
                cur.err = err;
                cur.lat = i - start;
                log_q.push_back(cur);
                in_txn = 1'b0;
                if (if_done) if_req = 1'b0;
                if (ls_done) ls_req = 1'b0;
            end
            mem_bus.ready = in_txn && mem_bus.req && latency > 0 &&
                            cur.req_cycles == latency;
            mem_bus.rdata = mem_bus.ready ? rd : 16'($urandom);
            if (toggle) ls_addr = 16'($urandom);
        end
        mem_bus.ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (mem_bus.req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_bus.req); end
        checks++; if (mem_bus.we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_bus.we); end
        checks++; if (mem_bus.addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", mem_bus.addr); end
        checks++; if (mem_bus.wdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0000", mem_bus.wdata); end
        checks++; if ({if_done, ls_done, err} !== 3'b000) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 000", {if_done, ls_done, err}); end
        checks++; if (if_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_if_rdata: got %h expected 0000", if_rdata); end
        checks++; if (ls_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_ls_rdata: got %h expected 0000", ls_rdata); end
        exp_last = 1;
        exp_if_rdata = 16'h0000;
        exp_ls_rdata = 16'h0000;
        reset = 1'b1;
    endtask

    task automatic test_tie_round_robin();
        int exp_g[4];
        logic [15:0] rd[2];
        rd[0] = 16'h1111;
        rd[1] = 16'h2222;
        for (int r = 0; r < 2; r++) begin
            if_addr = 16'h0100; ls_addr = 16'h0200; ls_we = 1'b0;
            if_req = 1'b1; ls_req = 1'b1;
            exp_g[2*r]   = grant_rr(1'b1, 1'b1);
            exp_g[2*r+1] = grant_rr(exp_g[2*r] == 1, exp_g[2*r] == 0);
            serve(r + 1, rd[r], 16, 1'b0);
            checks++; if (log_q.size() != 2) begin errors++; $display("[TB] FAIL tie_done_count: got %0d expected 2", log_q.size()); end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (k >= log_q.size() || log_q[k].port != exp_g[2*r+k]) begin
                    errors++;
                    $display("[TB] FAIL tie_grant_order[%0d]: got %0d expected %0d", 2*r+k,
                             (k < log_q.size()) ? log_q[k].port : -1, exp_g[2*r+k]);
                end
            end
            exp_if_rdata = rd[r];
            exp_ls_rdata = rd[r];
            checks++; if (if_rdata !== exp_if_rdata || ls_rdata !== exp_ls_rdata) begin errors++; $display("[TB] FAIL tie_rdata: got %h/%h expected %h/%h", if_rdata, ls_rdata, exp_if_rdata, exp_ls_rdata); end
        end
        // Fixed expectation for the first ties after reset: IF, LS, IF, LS.
        checks++; if (exp_g[0] != 0 || exp_g[1] != 1 || exp_g[2] != 0 || exp_g[3] != 1) begin errors++; $display("[TB] FAIL tie_model_order: got %0d%0d%0d%0d expected 0101", exp_g[0], exp_g[1], exp_g[2], exp_g[3]); end
    endtask

    task automatic test_fetch();
        int g;
        if_addr = 16'h0004; if_req = 1'b1;
        g = grant_rr(1'b1, 1'b0);
        serve(1, 16'hA5A5, 6, 1'b0);
        exp_if_rdata = 16'hA5A5;
        checks++; if (log_q.size() != 1) begin errors++; $display("[TB] FAIL fetch_done_count: got %0d expected 1", log_q.size()); end
        if (log_q.size() > 0) begin
            checks++; if (log_q[0].port != g) begin errors++; $display("[TB] FAIL fetch_port: got %0d expected %0d", log_q[0].port, g); end
            checks++; if (log_q[0].addr !== 16'h0004 || log_q[0].we !== 1'b0 || log_q[0].wdata !== 16'h0000) begin errors++; $display("[TB] FAIL fetch_bus: got %h/%b/%h expected 0004/0/0000", log_q[0].addr, log_q[0].we, log_q[0].wdata); end
            checks++; if (log_q[0].lat != 1 || log_q[0].err !== 1'b0) begin errors++; $display("[TB] FAIL fetch_latency: got lat %0d err %b expected lat 1 err 0", log_q[0].lat, log_q[0].err); end
        end
        checks++; if (if_rdata !== exp_if_rdata) begin errors++; $display("[TB] FAIL fetch_rdata: got %h expected %h", if_rdata, exp_if_rdata); end
    endtask

    task automatic test_store();
        int g;
        ls_we = 1'b1; ls_addr = 16'h0010; ls_wdata = 16'h1234; ls_req = 1'b1;
        g = grant_rr(1'b0, 1'b1);
        serve(2, 16'hBEEF, 8, 1'b0);
        ls_we = 1'b0;
        checks++; if (log_q.size() != 1) begin errors++; $display("[TB] FAIL store_done_count: got %0d expected 1", log_q.size()); end
        if (log_q.size() > 0) begin
            checks++; if (log_q[0].port != g) begin errors++; $display("[TB] FAIL store_port: got %0d expected %0d", log_q[0].port, g); end
            checks++; if (log_q[0].addr !== 16'h0010 || log_q[0].we !== 1'b1 || log_q[0].wdata !== 16'h1234) begin errors++; $display("[TB] FAIL store_bus: got %h/%b/%h expected 0010/1/1234", log_q[0].addr, log_q[0].we, log_q[0].wdata); end
        end
        checks++; if (ls_rdata !== exp_ls_rdata) begin errors++; $display("[TB] FAIL store_rdata_kept: got %h expected %h", ls_rdata, exp_ls_rdata); end
    endtask

    task automatic test_timeout();
        int g;
        ls_we = 1'b0; ls_addr = 16'h0020; ls_req = 1'b1;
        g = grant_rr(1'b0, 1'b1);
        serve(0, 16'h0000, TIMEOUT + 7, 1'b0);
        exp_ls_rdata = 16'h0000;
        checks++; if (log_q.size() != 1) begin errors++; $display("[TB] FAIL timeout_done_count: got %0d expected 1", log_q.size()); end
        if (log_q.size() > 0) begin
            checks++; if (log_q[0].port != g || log_q[0].err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_done_err: got port %0d err %b expected port %0d err 1", log_q[0].port, log_q[0].err, g); end
            checks++; if (log_q[0].req_cycles != TIMEOUT || log_q[0].lat != TIMEOUT) begin errors++; $display("[TB] FAIL timeout_req_cycles: got %0d/%0d expected %0d", log_q[0].req_cycles, log_q[0].lat, TIMEOUT); end
        end
        checks++; if (ls_rdata !== exp_ls_rdata || if_rdata !== exp_if_rdata) begin errors++; $display("[TB] FAIL timeout_rdata: got %h/%h expected %h/%h", ls_rdata, if_rdata, exp_ls_rdata, exp_if_rdata); end
    endtask

    task automatic test_reset_mid_access();
        int g;
        bit saw_done = 1'b0;
        if_addr = 16'h0040; if_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_bus.req !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_access: got %b expected 1", mem_bus.req); end
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_bus.req !== 1'b0 || if_done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_async: got req %b done %b expected 0 0", mem_bus.req, if_done); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (if_done || ls_done) saw_done = 1'b1;
        end
        reset = 1'b1;
        exp_last = 1;
        exp_if_rdata = 16'h0000;
        exp_ls_rdata = 16'h0000;
        checks++; if (saw_done) begin errors++; $display("[TB] FAIL midreset_no_done: got 1 expected 0"); end
        checks++; if (if_rdata !== exp_if_rdata) begin errors++; $display("[TB] FAIL midreset_rdata_cleared: got %h expected %h", if_rdata, exp_if_rdata); end
        if_addr = 16'h0044;
        g = grant_rr(1'b1, 1'b0);
        serve(1, 16'h5A5A, 6, 1'b0);
        exp_if_rdata = 16'h5A5A;
        checks++; if (log_q.size() != 1 || (log_q.size() > 0 && (log_q[0].port != g || log_q[0].addr !== 16'h0044))) begin errors++; $display("[TB] FAIL midreset_regrant: got %0d txns expected 1 IF txn at 0044", log_q.size()); end
        checks++; if (if_rdata !== exp_if_rdata) begin errors++; $display("[TB] FAIL midreset_regrant_rdata: got %h expected %h", if_rdata, exp_if_rdata); end
    endtask

    task automatic test_addr_toggle();
        int g;
        ls_we = 1'b0; ls_addr = 16'h0300; ls_req = 1'b1;
        g = grant_rr(1'b0, 1'b1);
        serve(4, 16'h7E57, 12, 1'b1);
        exp_ls_rdata = 16'h7E57;
        checks++; if (log_q.size() != 1) begin errors++; $display("[TB] FAIL toggle_done_count: got %0d expected 1", log_q.size()); end
        if (log_q.size() > 0) begin
            checks++; if (log_q[0].port != g || log_q[0].addr !== 16'h0300 || !log_q[0].stable) begin errors++; $display("[TB] FAIL toggle_addr_stable: got port %0d addr %h stable %b expected %0d 0300 1", log_q[0].port, log_q[0].addr, log_q[0].stable, g); end
            checks++; if (log_q[0].req_cycles != 4) begin errors++; $display("[TB] FAIL toggle_req_cycles: got %0d expected 4", log_q[0].req_cycles); end
        end
        checks++; if (ls_rdata !== exp_ls_rdata) begin errors++; $display("[TB] FAIL toggle_rdata: got %h expected %h", ls_rdata, exp_ls_rdata); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            bit          a_if, a_ls, we_v;
            int          lat, n, exp_cycles;
            int          g[2];
            logic [15:0] ia, la, wd, rd;
            a_if = 1'($urandom_range(0, 1));
            a_ls = 1'($urandom_range(0, 1));
            if (!a_if && !a_ls) a_if = 1'b1;
            lat  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 4));
            ia = 16'($urandom); la = 16'($urandom); wd = 16'($urandom); rd = 16'($urandom);
            we_v = 1'($urandom_range(0, 1));
            if_addr = ia; ls_addr = la; ls_wdata = wd; ls_we = we_v;
            g[0] = grant_rr(a_if, a_ls);
            n = 1;
            g[1] = 0;
            if (a_if && a_ls) begin
                g[1] = grant_rr(g[0] == 1, g[0] == 0);
                n = 2;
            end
            exp_cycles = (lat == 0) ? TIMEOUT : lat;
            if_req = a_if; ls_req = a_ls;
            serve(lat, rd, n * (exp_cycles + 3) + 3, 1'b0);
            if_req = 1'b0; ls_req = 1'b0;
            checks++; if (log_q.size() != n) begin errors++; $display("[TB] FAIL rand%0d_done_count: got %0d expected %0d", it, log_q.size(), n); end
            for (int k = 0; k < n && k < log_q.size(); k++) begin
                logic [15:0] e_addr, e_wdata;
                logic        e_we;
                e_addr  = (g[k] == 1) ? la : ia;
                e_we    = (g[k] == 1) ? we_v : 1'b0;
                e_wdata = (g[k] == 1 && we_v) ? wd : 16'h0000;
                checks++;
                if (log_q[k].port != g[k] || log_q[k].addr !== e_addr || log_q[k].we !== e_we ||
                    log_q[k].wdata !== e_wdata || log_q[k].err !== (lat == 0) ||
                    log_q[k].req_cycles != exp_cycles) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_txn%0d: got port %0d addr %h we %b wdata %h err %b cyc %0d expected %0d %h %b %h %b %0d",
                             it, k, log_q[k].port, log_q[k].addr, log_q[k].we, log_q[k].wdata, log_q[k].err,
                             log_q[k].req_cycles, g[k], e_addr, e_we, e_wdata, (lat == 0), exp_cycles);
                end
            end
            for (int k = 0; k < n; k++) begin
                if (g[k] == 0)      exp_if_rdata = (lat == 0) ? 16'h0000 : rd;
                else if (!we_v)     exp_ls_rdata = (lat == 0) ? 16'h0000 : rd;
            end
            checks++; if (if_rdata !== exp_if_rdata || ls_rdata !== exp_ls_rdata) begin errors++; $display("[TB] FAIL rand%0d_rdata: got %h/%h expected %h/%h", it, if_rdata, ls_rdata, exp_if_rdata, exp_ls_rdata); end
        end
    endtask

    initial begin
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        mem_bus.ready = 1'b0; mem_bus.rdata = '0;
        exp_last = 1;
        exp_if_rdata = '0;
        exp_ls_rdata = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_tie_round_robin();
        test_fetch();
        test_store();
        test_timeout();
        test_reset_mid_access();
        test_addr_toggle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
